booth_wrapper: RTL and testbench

BOOTH_WRAPPER -- requirements
Module: booth_wrapper

---
 rtl/elliptic_curve_structs.sv | 4 +
 rtl/booth_radix4_core.sv | 72 +++++++
 rtl/booth_wrapper.sv | 76 +++++++
 tb/tb_booth_wrapper.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/elliptic_curve_structs.sv
// Shared constants for the elliptic-curve datapath blocks.
package elliptic_curve_structs;
  localparam int P_WIDTH = 256;
endpackage

// File: rtl/booth_radix4_core.sv
// Sequential radix-4 Booth datapath: digit recoder, add/subtract, shift registers
// and step counter. One signed digit of the multiplier is retired per step.
module booth_radix4_core #(
  parameter int width = 256,
  parameter int cnt_w = $clog2(width / 2 + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [width+1:0]     mcand_in,
  input  logic [width+1:0]     mplier_in,
  output logic [2*width-1:0]   product,
  output logic [cnt_w-1:0]     count
);
  // The exact product fits in 2*width bits, so modular two's-complement arithmetic
  // at that width yields the correct final value even though partial sums go negative.
  localparam int acc_w = 2 * width;

  logic [acc_w-1:0] acc;
  logic [acc_w-1:0] mcand;
  logic [acc_w-1:0] mag;
  logic [acc_w-1:0] addend;
  logic [width+1:0] mplier;
  logic             prev;
  logic             negate;

  // Recode {b[2i+1], b[2i], b[2i-1]} into a digit in {-2,-1,0,+1,+2}.
  always_comb begin
    mag    = '0;
    negate = 1'b0;
    case ({mplier[1:0], prev})
      3'b001, 3'b010: mag = mcand;
      3'b011:         mag = mcand << 1;
      3'b100: begin
        mag    = mcand << 1;
        negate = 1'b1;
      end
      3'b101, 3'b110: begin
        mag    = mcand;
        negate = 1'b1;
      end
      default:        mag = '0;
    endcase
    addend = negate ? ~mag : mag;
  end

  // Accumulate one digit per step while shifting the operands two places.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prev   <= 1'b0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{(acc_w - width - 2){1'b0}}, mcand_in};
      mplier <= mplier_in;
      prev   <= 1'b0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc + addend + {{(acc_w - 1){1'b0}}, negate};
      mcand  <= mcand << 2;
      mplier <= mplier >> 2;
      prev   <= mplier[1];
      count  <= count + {{(cnt_w - 1){1'b0}}, 1'b1};
    end
  end

  assign product = acc;
endmodule

// File: rtl/booth_wrapper.sv
// Unsigned width x width multiplier: IDLE/RUN/DONE control around the radix-4 Booth
// core, with the product and done flag held in output registers.
module booth_wrapper
  import elliptic_curve_structs::*;
#(
  parameter int width = P_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] ab,
  output logic               done
);
  localparam int cnt_w = $clog2(width / 2 + 2);
  localparam logic [cnt_w-1:0] last_step = cnt_w'(width / 2 + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic               load;
  logic               step;
  logic [2*width-1:0] product;
  logic [cnt_w-1:0]   count;

  assign load = (state == IDLE) && enable;
  assign step = (state == RUN) && enable && (count != last_step);

  // Two zero bits on top keep the final Booth digit non-negative for unsigned operands.
  booth_radix4_core #(.width(width)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .mcand_in  ({2'b00, a}),
    .mplier_in ({2'b00, b}),
    .product   (product),
    .count     (count)
  );

  // Control FSM; ab only changes when entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      ab    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (count == last_step) begin
            state <= DONE;
            ab    <= product;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!enable) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_wrapper.sv
// Scoreboard bench for booth_wrapper at width 8 (index 0) and width 256 (index 1).
module tb_booth_wrapper;
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   en;
  logic [1:0]   done_v;
  logic [255:0] a_s [2];
  logic [255:0] b_s [2];
  logic [15:0]  ab8;
  logic [511:0] ab256;
  logic [511:0] ab_v [2];

  typedef struct {
    int           idx;
    logic [511:0] prod;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [511:0] last_p [2];
  logic [1:0]   prev_done = 2'b00;
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;

  booth_wrapper #(.width(8)) dut8 (
    .clk(clk), .reset(reset), .enable(en[0]),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .ab(ab8), .done(done_v[0])
  );

  booth_wrapper dut256 (
    .clk(clk), .reset(reset), .enable(en[1]),
    .a(a_s[1]), .b(b_s[1]), .ab(ab256), .done(done_v[1])
  );

  assign ab_v[0] = {496'b0, ab8};
  assign ab_v[1] = ab256;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 256;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every rising done is matched against the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_v[i] && !prev_done[i]) begin
        if (sb.size() == 0) begin
          check("spurious_done", done_v[i], 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_idx", i, mon_e.idx);
          check("sb_ab", ab_v[i], mon_e.prod);
          check("latency", cyc, mon_e.due);
        end
      end
    end
    prev_done <= done_v;
  end

  task automatic run_op(input int i, input logic [255:0] a, input logic [255:0] b,
                        input int hold, input bit scramble);
    logic [255:0] m;
    logic [511:0] exp_p;
    exp_t         e;
    bit           got;
    int           w;
    w = wd(i);
    m = (i == 0) ? 256'hFF : {256{1'b1}};
    a = a & m;
    b = b & m;
    exp_p = {256'b0, a} * {256'b0, b};
    @(negedge clk);
    a_s[i] = a;
    b_s[i] = b;
    en[i]  = 1'b1;
    e.idx  = i;
    e.prod = exp_p;
    e.due  = cyc + w / 2 + 3;
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < w / 2 + 10 && !got; k++) begin
      @(negedge clk);
      if (done_v[i]) got = 1'b1;
      else if (scramble) begin
        a_s[i] = rnd256();
        b_s[i] = rnd256();
      end
    end
    check("done_timeout", got, 1);
    if (!got) sb.delete();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_done", done_v[i], 1);
      check("hold_ab", ab_v[i], exp_p);
    end
    en[i] = 1'b0;
    @(negedge clk);
    check("drop_done", done_v[i], 0);
    check("keep_ab", ab_v[i], exp_p);
    last_p[i] = exp_p;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    en    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_s[i] = '0;
      b_s[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_done", done_v[i], 0);
      check("reset_ab", ab_v[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    run_op(1, 256'ha061fedbd0f036687a3b46fadcfb7bc7a76ed8ea6dab88b26f1408590510cc1e,
              256'hdb26c704eefedca6f22c27666c22ed58703bcc4f56fd507907d37b085d79e091, 3, 1'b0);
    run_op(0, 256'hFF, 256'hFF, 2, 1'b0);
    run_op(0, 256'h00, 256'hA5, 1, 1'b0);
    run_op(0, 256'h01, 256'hA5, 1, 1'b0);
    run_op(0, 256'h80, 256'h80, 2, 1'b0);

    // Enable dropped mid-run: no done, previous product held.
    @(negedge clk);
    a_s[0] = 256'h5A;
    b_s[0] = 256'hC3;
    en[0]  = 1'b1;
    repeat (3) @(negedge clk);
    en[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_done", done_v[0], 0);
    check("abort_ab", ab_v[0], last_p[0]);

    // Reset three cycles into RUN discards the partial product.
    @(negedge clk);
    a_s[0] = 256'h77;
    b_s[0] = 256'h99;
    en[0]  = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_done", done_v[0], 0);
    check("midrst_ab", ab_v[0], 0);
    check("midrst_ab256", ab_v[1], 0);
    en[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_idle", done_v[0], 0);
    run_op(0, 256'h03, 256'h05, 1, 1'b0);

    for (int n = 0; n < 5; n++) run_op(0, rnd256(), rnd256(), $urandom_range(3, 0), 1'b1);
    for (int n = 0; n < 3; n++) run_op(1, rnd256(), rnd256(), $urandom_range(3, 0), 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
